// File: rtl/drive_cmd_controller_if.sv
// Bus between the drive command controller and its environment: UART receiver
// bytes, line-follower inputs, and the drive/diagnostic outputs.
interface drive_cmd_controller_if;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic [1:0] i_Auto_CMD;
    logic       i_Line_Lost;
    logic [1:0] o_DriveCMD;
    logic       o_Auto_Mode;
    logic       o_Frame_OK;
    logic       o_Frame_Err;
    logic       o_Wdog_Trip;
    logic [7:0] o_Err_Count;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Auto_CMD, i_Line_Lost,
        input  o_DriveCMD, o_Auto_Mode, o_Frame_OK, o_Frame_Err, o_Wdog_Trip, o_Err_Count
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Auto_CMD, i_Line_Lost,
        output o_DriveCMD, o_Auto_Mode, o_Frame_OK, o_Frame_Err, o_Wdog_Trip, o_Err_Count
    );
endinterface

// File: rtl/drive_cmd_controller.sv
// Parses '$' CMD LF frames from the UART byte stream, selects manual or
// line-follower drive, and enforces the command watchdog and inter-byte timeout.
module drive_cmd_controller #(
    parameter int WDOG_CLKS    = 25000000,
    parameter int WDOG_W       = 25,
    parameter int BYTE_TIMEOUT = 104160,
    parameter int TO_W         = 17
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_n,
    drive_cmd_controller_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GOT_HDR = 2'd1;
    localparam logic [1:0] GOT_CMD = 2'd2;
    localparam logic [1:0] APPLY   = 2'd3;

    localparam logic [7:0] CH_HDR  = 8'h24;
    localparam logic [7:0] CH_EOF  = 8'h0A;
    localparam logic [7:0] CH_AUTO = 8'h41;
    localparam logic [7:0] CH_MAN  = 8'h4D;

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CLKS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(BYTE_TIMEOUT - 1);

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == 8'h30) || (b == 8'h31) || (b == 8'h32) ||
               (b == CH_AUTO) || (b == CH_MAN);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              auto_q, auto_d;
    logic [1:0]        mcmd_q, mcmd_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              trip_q, trip_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic [7:0]        errcnt_q, errcnt_d;
    logic [1:0]        drive_q, drive_d;
    logic              err_s;

    // Frame parser, byte timeout, watchdog and output mux next-state logic
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        auto_d   = auto_q;
        mcmd_d   = mcmd_q;
        to_d     = to_q;
        wdog_d   = wdog_q;
        trip_d   = trip_q;
        err_s    = 1'b0;

        case (state_q)
            IDLE, APPLY: begin
                to_d = '0;
                if (bus.i_Rx_DV && (bus.i_Rx_Byte == CH_HDR)) begin
                    state_d = GOT_HDR;
                end else begin
                    state_d = IDLE;
                end
            end
            GOT_HDR: begin
                if (bus.i_Rx_DV) begin
                    to_d = '0;
                    if (is_cmd(bus.i_Rx_Byte)) begin
                        cmd_d   = bus.i_Rx_Byte;
                        state_d = GOT_CMD;
                    end else if (bus.i_Rx_Byte == CH_HDR) begin
                        err_s   = 1'b1;
                    end else begin
                        err_s   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    err_s   = 1'b1;
                    to_d    = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            GOT_CMD: begin
                if (bus.i_Rx_DV) begin
                    to_d = '0;
                    if (bus.i_Rx_Byte == CH_EOF) begin
                        state_d = APPLY;
                    end else if (bus.i_Rx_Byte == CH_HDR) begin
                        err_s   = 1'b1;
                        state_d = GOT_HDR;
                    end else begin
                        err_s   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    err_s   = 1'b1;
                    to_d    = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: begin
                to_d    = '0;
                state_d = IDLE;
            end
        endcase

        // Watchdog saturates at its last count, keeping the manual command forced to stop
        if (auto_q) begin
            wdog_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
            trip_d = 1'b1;
            mcmd_d = 2'd0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end

        // A completed frame overrides whatever the watchdog decided this cycle
        if (state_q == APPLY) begin
            ok_d   = 1'b1;
            wdog_d = '0;
            trip_d = 1'b0;
            case (cmd_q)
                8'h30, 8'h31, 8'h32: begin
                    auto_d = 1'b0;
                    mcmd_d = cmd_q[1:0];
                end
                CH_AUTO: auto_d = 1'b1;
                CH_MAN:  auto_d = 1'b0;
                default: auto_d = auto_q;
            endcase
        end else begin
            ok_d = 1'b0;
        end

        err_d    = err_s;
        errcnt_d = err_s ? sat_inc(errcnt_q) : errcnt_q;

        if (auto_q) begin
            drive_d = bus.i_Line_Lost ? 2'd0 : bus.i_Auto_CMD;
        end else begin
            drive_d = mcmd_q;
        end
    end

    // State and output registers
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= 8'h00;
            auto_q   <= 1'b0;
            mcmd_q   <= 2'd0;
            to_q     <= '0;
            wdog_q   <= '0;
            trip_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= 8'h00;
            drive_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            auto_q   <= auto_d;
            mcmd_q   <= mcmd_d;
            to_q     <= to_d;
            wdog_q   <= wdog_d;
            trip_q   <= trip_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            drive_q  <= drive_d;
        end
    end

    assign bus.o_DriveCMD  = drive_q;
    assign bus.o_Auto_Mode = auto_q;
    assign bus.o_Frame_OK  = ok_q;
    assign bus.o_Frame_Err = err_q;
    assign bus.o_Wdog_Trip = trip_q;
    assign bus.o_Err_Count = errcnt_q;

endmodule

// File: tb/tb_drive_cmd_controller.sv
// Directed bench for drive_cmd_controller with shortened watchdog (1000) and
// byte timeout (500); expected values are hand-derived from the frame timing.
module tb_drive_cmd_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    drive_cmd_controller_if bus ();

    drive_cmd_controller #(
        .WDOG_CLKS    (1000),
        .WDOG_W       (10),
        .BYTE_TIMEOUT (500),
        .TO_W         (9)
    ) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge: byte is sampled at the next posedge, returns at the following negedge
    task automatic send_byte(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        @(negedge clk);
        bus.i_Rx_DV   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c);
        send_byte(8'h24);
        idle(3);
        send_byte(c);
        idle(3);
        send_byte(8'h0A);
    endtask

    task automatic check_all_reset(input string tag);
        check_val({tag, "_drive"}, 8'(bus.o_DriveCMD), 8'd0);
        check_val({tag, "_auto"},  8'(bus.o_Auto_Mode), 8'd0);
        check_val({tag, "_ok"},    8'(bus.o_Frame_OK), 8'd0);
        check_val({tag, "_err"},   8'(bus.o_Frame_Err), 8'd0);
        check_val({tag, "_trip"},  8'(bus.o_Wdog_Trip), 8'd0);
        check_val({tag, "_cnt"},   bus.o_Err_Count, 8'd0);
    endtask

    initial begin
        bus.i_Rx_DV     = 1'b0;
        bus.i_Rx_Byte   = 8'h00;
        bus.i_Auto_CMD  = 2'd0;
        bus.i_Line_Lost = 1'b0;
        idle(3);
        check_all_reset("rst");
        rst_n = 1'b1;

        // Manual forward frame
        send_frame(8'h31);
        check_val("t1_ok_early", 8'(bus.o_Frame_OK), 8'd0);
        idle(1);
        check_val("t1_ok", 8'(bus.o_Frame_OK), 8'd1);
        check_val("t1_drive_early", 8'(bus.o_DriveCMD), 8'd0);
        idle(1);
        check_val("t1_ok_end", 8'(bus.o_Frame_OK), 8'd0);
        check_val("t1_drive", 8'(bus.o_DriveCMD), 8'd1);
        check_val("t1_auto", 8'(bus.o_Auto_Mode), 8'd0);

        // Auto mode and line-lost override
        bus.i_Auto_CMD = 2'd2;
        send_frame(8'h41);
        idle(2);
        check_val("t2_auto", 8'(bus.o_Auto_Mode), 8'd1);
        check_val("t2_drive", 8'(bus.o_DriveCMD), 8'd2);
        bus.i_Line_Lost = 1'b1;
        idle(1);
        check_val("t2_lost", 8'(bus.o_DriveCMD), 8'd0);
        bus.i_Line_Lost = 1'b0;
        idle(1);
        check_val("t2_found", 8'(bus.o_DriveCMD), 8'd2);
        bus.i_Auto_CMD = 2'd3;
        idle(1);
        check_val("t2_pass3", 8'(bus.o_DriveCMD), 8'd3);
        bus.i_Auto_CMD = 2'd2;
        idle(20);
        check_val("t2_no_trip", 8'(bus.o_Wdog_Trip), 8'd0);

        // Watchdog: trip 1000 edges after APPLY, drive stops one edge later
        send_frame(8'h31);
        idle(1);
        check_val("t3_ok", 8'(bus.o_Frame_OK), 8'd1);
        idle(999);
        check_val("t3_trip_early", 8'(bus.o_Wdog_Trip), 8'd0);
        check_val("t3_drive_run", 8'(bus.o_DriveCMD), 8'd1);
        idle(1);
        check_val("t3_trip", 8'(bus.o_Wdog_Trip), 8'd1);
        idle(1);
        check_val("t3_drive_stop", 8'(bus.o_DriveCMD), 8'd0);
        send_frame(8'h30);
        idle(1);
        check_val("t3_clear_ok", 8'(bus.o_Frame_OK), 8'd1);
        check_val("t3_clear_trip", 8'(bus.o_Wdog_Trip), 8'd0);

        // Bad CMD, stray LF in IDLE, resync on repeated '$'
        send_byte(8'h24);
        idle(3);
        send_byte(8'h35);
        check_val("t4_err1", 8'(bus.o_Frame_Err), 8'd1);
        idle(1);
        check_val("t4_err1_end", 8'(bus.o_Frame_Err), 8'd0);
        check_val("t4_cnt1", bus.o_Err_Count, 8'd1);
        send_byte(8'h0A);
        check_val("t4_lf_ignored", 8'(bus.o_Frame_Err), 8'd0);
        idle(1);
        check_val("t4_lf_cnt", bus.o_Err_Count, 8'd1);
        send_byte(8'h24);
        idle(3);
        send_byte(8'h24);
        check_val("t4_resync_err", 8'(bus.o_Frame_Err), 8'd1);
        idle(3);
        send_byte(8'h32);
        idle(3);
        send_byte(8'h0A);
        idle(2);
        check_val("t4_drive", 8'(bus.o_DriveCMD), 8'd2);
        check_val("t4_cnt2", bus.o_Err_Count, 8'd2);

        // Byte timeout after '$'
        send_byte(8'h24);
        idle(499);
        check_val("t5_to_early", 8'(bus.o_Frame_Err), 8'd0);
        idle(1);
        check_val("t5_to_err", 8'(bus.o_Frame_Err), 8'd1);
        idle(1);
        check_val("t5_to_cnt", bus.o_Err_Count, 8'd3);
        send_byte(8'h31);
        check_val("t5_idle_ignores", 8'(bus.o_Frame_Err), 8'd0);

        // DV on the timeout edge wins
        send_byte(8'h24);
        idle(499);
        send_byte(8'h31);
        check_val("t5_dv_wins", 8'(bus.o_Frame_Err), 8'd0);
        send_byte(8'h0A);
        idle(1);
        check_val("t5_dv_ok", 8'(bus.o_Frame_OK), 8'd1);
        idle(1);
        check_val("t5_dv_drive", 8'(bus.o_DriveCMD), 8'd1);
        check_val("t5_dv_cnt", bus.o_Err_Count, 8'd3);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h24);
            send_byte(8'h5A);
        end
        idle(1);
        check_val("t6_sat", bus.o_Err_Count, 8'd255);

        // Reset between '$' and CMD
        send_byte(8'h24);
        #2 rst_n = 1'b0;
        #1 check_all_reset("t7_async");
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h31);
        check_val("t7_cmd_err", 8'(bus.o_Frame_Err), 8'd0);
        send_byte(8'h0A);
        check_val("t7_lf_err", 8'(bus.o_Frame_Err), 8'd0);
        idle(1);
        check_val("t7_no_ok", 8'(bus.o_Frame_OK), 8'd0);
        idle(1);
        check_val("t7_drive", 8'(bus.o_DriveCMD), 8'd0);
        check_val("t7_cnt", bus.o_Err_Count, 8'd0);
        check_val("t7_auto", 8'(bus.o_Auto_Mode), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/drive_cmd_controller.md
Name: drive_cmd_controller

Overview:
Command sequencer between the UART receiver and the motor drive logic. It parses framed ASCII commands from the receiver byte stream and selects between manual drive commands and the autonomous line-follower command. It also enforces a command watchdog and an inter-byte timeout, and keeps a saturating frame-error count for diagnostics.

Parameters:
WDOG_CLKS, 25000000, clocks without a valid frame in manual mode before forcing stop (0.5 s at 50 MHz)
WDOG_W, 25, watchdog counter width; must satisfy 2^WDOG_W > WDOG_CLKS
BYTE_TIMEOUT, 104160, max clocks between bytes inside a frame (20 bit-times at 9600 baud, 50 MHz)
TO_W, 17, byte-timeout counter width; must satisfy 2^TO_W > BYTE_TIMEOUT

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Rx_DV  in  1  one-cycle pulse: i_Rx_Byte valid
i_Rx_Byte  in  8  received byte
i_Auto_CMD  in  2  drive command from the line-follower logic
i_Line_Lost  in  1  level: sensors see no line
o_DriveCMD  out  2  registered drive command to the motor block (0 stop, 1 forward, 2 turn)
o_Auto_Mode  out  1  1 = autonomous mode, 0 = manual mode
o_Frame_OK  out  1  one-cycle pulse: valid frame applied
o_Frame_Err  out  1  one-cycle pulse: frame rejected
o_Wdog_Trip  out  1  level: watchdog forced stop in manual mode
o_Err_Count  out  8  saturating count of rejected frames

Behaviour:
- Reset (async assert, sync release): state IDLE; manual mode; manual cmd 0; o_DriveCMD 0; o_Auto_Mode 0; o_Frame_OK 0; o_Frame_Err 0; o_Wdog_Trip 0; o_Err_Count 0; all counters 0.
- Frame format: 0x24 '$', then CMD, then 0x0A. Valid CMD values:
  - 0x30/0x31/0x32: manual cmd 0/1/2 and select manual mode.
  - 0x41 'A': select auto mode; manual cmd unchanged.
  - 0x4D 'M': select manual mode; manual cmd unchanged.
- States and transitions; bytes are evaluated only on edges where i_Rx_DV=1:
  - IDLE: '$' goes to GOT_HDR. Any other byte is ignored silently.
  - GOT_HDR: valid CMD is latched and goes to GOT_CMD. '$' counts as an error and stays in GOT_HDR (resync). Any other byte is an error and goes to IDLE.
  - GOT_CMD: 0x0A goes to APPLY. '$' counts as an error and goes to GOT_HDR. Any other byte is an error and goes to IDLE.
  - APPLY: one cycle. Updates mode and manual cmd, pulses o_Frame_OK, clears the watchdog counter and o_Wdog_Trip, then goes to IDLE. A DV in APPLY is evaluated with IDLE rules.
- Latency: terminator DV sampled at edge N. At edge N+1 (APPLY), mode and manual cmd are updated and o_Frame_OK goes high for one cycle. The new o_DriveCMD is visible after edge N+2.
- Error action: o_Frame_Err pulses for one cycle after the deciding edge. o_Err_Count increments and saturates at 255 (no wrap).
- Byte timeout:
  - The counter runs in GOT_HDR/GOT_CMD, is cleared by every DV, and is held at 0 in IDLE/APPLY.
  - At count BYTE_TIMEOUT-1: error action and go to IDLE.
  - If DV arrives on the same edge as the timeout, DV wins and no timeout occurs.
- Watchdog:
  - Counts every clock in manual mode. Held at 0 in auto mode. Cleared in APPLY.
  - At count WDOG_CLKS-1: o_Wdog_Trip set to 1, manual cmd forced to 0, and the counter holds.
  - Trip clears only on the next o_Frame_OK. Entering auto mode via a frame clears it, because APPLY clears it.
- Output mux (registered, every edge):
  - Auto mode: o_DriveCMD = i_Line_Lost ? 0 : i_Auto_CMD.
  - Manual mode: o_DriveCMD = manual cmd.
  - An i_Auto_CMD value of 3 is passed through unchanged.
- Reset mid-frame: abandons the frame immediately and forces all reset values; no error is counted.

Test Plan:
- Bytes 24,31,0A (hex), DV pulses 5208*10 clocks apart -> o_Frame_OK pulse 1 cycle after terminator DV; o_DriveCMD=1 one cycle later; o_Auto_Mode=0.
- Bytes 24,41,0A; i_Auto_CMD=2, then i_Line_Lost=1 -> o_Auto_Mode=1; o_DriveCMD=2, then 0 one clock after Line_Lost rises; returns to 2 when it falls.
- Manual cmd 1, then no DV (bench WDOG_CLKS=1000) -> o_Wdog_Trip=1 and o_DriveCMD=0 at clock ~1001; frame 24,30,0A clears trip.
- Bytes 24,35,0A, then 24,24,32,0A -> one o_Frame_Err for 0x35; 0x0A ignored in IDLE; resync error on second '$'; o_Err_Count=2; final o_DriveCMD=2.
- Byte 24 then silence (BYTE_TIMEOUT=500) -> o_Frame_Err at clock 500; state IDLE; a DV on the timeout edge is accepted instead. Force 300 errors -> o_Err_Count stays 255.
- Assert i_Rst_n low between '$' and CMD -> all outputs reset asynchronously; following 31,0A ignored; o_Err_Count=0.
